// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 4-stage pipeline: load-use stalls, taken-branch
// redirect/flush, ALU operand forwarding selects and saturating debug event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned ASIZE        = 5,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] rs_ID,
  input  logic [ASIZE-1:0] rt_ID,
  input  logic             uses_rt_ID,
  input  logic [ASIZE-1:0] waddr_EX,
  input  logic             wen_EX,
  input  logic             memread_EX,
  input  logic [ASIZE-1:0] waddr_MEM,
  input  logic             wen_MEM,
  input  logic             memread_MEM,
  input  logic [ASIZE-1:0] waddr_WB,
  input  logic             wen_WB,
  input  logic [ASIZE-1:0] rs_EX,
  input  logic [ASIZE-1:0] rt_EX,
  input  logic             branch_taken_EX,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             pc_redirect,
  output logic             flush_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StFlush
  } state_e;

  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       flush_rem_q, flush_rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             haz_ex, haz_mem;
  logic             pc_hold_c, ifid_hold_c, idex_bubble_c, pc_redirect_c, flush_id_c;
  logic [1:0]       fwd_a_c, fwd_b_c;

  // A load's data is only forwardable from WB, so a load in EX or MEM that feeds ID must stall.
  assign haz_ex = memread_EX & wen_EX & (waddr_EX != '0) &
                  ((waddr_EX == rs_ID) | (uses_rt_ID & (waddr_EX == rt_ID)));
  assign haz_mem = memread_MEM & wen_MEM & (waddr_MEM != '0) &
                   ((waddr_MEM == rs_ID) | (uses_rt_ID & (waddr_MEM == rt_ID)));

  always_comb begin
    state_d       = state_q;
    flush_rem_d   = flush_rem_q;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    idex_bubble_c = 1'b0;
    pc_redirect_c = 1'b0;
    flush_id_c    = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    unique case (state_q)
      StRun, StStall: begin
        if (branch_taken_EX) begin
          pc_redirect_c = 1'b1;
          flush_id_c    = 1'b1;
          idex_bubble_c = 1'b1;
          flush_inc     = 1'b1;
          flush_rem_d   = FlushInit;
          state_d       = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else if (haz_ex || haz_mem) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          stall_inc     = 1'b1;
          state_d       = StStall;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        // Only bubbles reach EX here, so hazards and branches are ignored.
        flush_id_c    = 1'b1;
        idex_bubble_c = 1'b1;
        flush_rem_d   = flush_rem_q - 2'd1;
        if (flush_rem_q <= 2'd1) begin
          flush_rem_d = '0;
          state_d     = StRun;
        end
      end
      default: begin
        state_d     = StRun;
        flush_rem_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      flush_rem_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      if (stall_inc && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_inc && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  // Forwarding: EX/MEM wins over WB; a load in EX/MEM has no result yet.
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (wen_MEM && !memread_MEM && (waddr_MEM != '0) && (waddr_MEM == rs_EX)) begin
      fwd_a_c = 2'b01;
    end else if (wen_WB && (waddr_WB != '0) && (waddr_WB == rs_EX)) begin
      fwd_a_c = 2'b10;
    end
    if (wen_MEM && !memread_MEM && (waddr_MEM != '0) && (waddr_MEM == rt_EX)) begin
      fwd_b_c = 2'b01;
    end else if (wen_WB && (waddr_WB != '0) && (waddr_WB == rt_EX)) begin
      fwd_b_c = 2'b10;
    end
  end

  // All outputs are forced low while reset is asserted, including the combinational ones.
  assign pc_hold     = pc_hold_c & ~rst;
  assign ifid_hold   = ifid_hold_c & ~rst;
  assign idex_bubble = idex_bubble_c & ~rst;
  assign pc_redirect = pc_redirect_c & ~rst;
  assign flush_id    = flush_id_c & ~rst;
  assign fwd_a       = rst ? 2'b00 : fwd_a_c;
  assign fwd_b       = rst ? 2'b00 : fwd_b_c;
  assign stall_cnt   = rst ? '0 : stall_cnt_q;
  assign flush_cnt   = rst ? '0 : flush_cnt_q;
  assign busy        = ~rst & (state_q != StRun);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stalls, forwarding, branch flush, priority,
// reset behaviour and counter saturation (second instance with a 4-bit counter).
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs_ID, rt_ID, waddr_EX, waddr_MEM, waddr_WB, rs_EX, rt_EX;
  logic       uses_rt_ID, wen_EX, memread_EX, wen_MEM, memread_MEM, wen_WB, branch_taken_EX;

  logic        pc_hold, ifid_hold, idex_bubble, pc_redirect, flush_id, busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_hold, s_ifid_hold, s_idex_bubble, s_pc_redirect, s_flush_id, s_busy;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .waddr_EX(waddr_EX), .wen_EX(wen_EX), .memread_EX(memread_EX),
    .waddr_MEM(waddr_MEM), .wen_MEM(wen_MEM), .memread_MEM(memread_MEM),
    .waddr_WB(waddr_WB), .wen_WB(wen_WB), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .branch_taken_EX(branch_taken_EX), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_bubble(idex_bubble), .pc_redirect(pc_redirect), .flush_id(flush_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy(busy)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .waddr_EX(waddr_EX), .wen_EX(wen_EX), .memread_EX(memread_EX),
    .waddr_MEM(waddr_MEM), .wen_MEM(wen_MEM), .memread_MEM(memread_MEM),
    .waddr_WB(waddr_WB), .wen_WB(wen_WB), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .branch_taken_EX(branch_taken_EX), .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold),
    .idex_bubble(s_idex_bubble), .pc_redirect(s_pc_redirect), .flush_id(s_flush_id),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
    .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control vector order: {pc_hold, ifid_hold, idex_bubble, pc_redirect, flush_id, busy}
  task automatic check_ctl(input string tag, input logic [5:0] exp);
    check_eq(tag, 32'({pc_hold, ifid_hold, idex_bubble, pc_redirect, flush_id, busy}),
             32'(exp));
  endtask

  task automatic clear_inputs();
    rs_ID = '0; rt_ID = '0; uses_rt_ID = 1'b0;
    waddr_EX = '0; wen_EX = 1'b0; memread_EX = 1'b0;
    waddr_MEM = '0; wen_MEM = 1'b0; memread_MEM = 1'b0;
    waddr_WB = '0; wen_WB = 1'b0;
    rs_EX = '0; rt_EX = '0; branch_taken_EX = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    wen_MEM = 1'b1; waddr_MEM = 5'd3; rs_EX = 5'd3; rt_EX = 5'd3;
    #2;
    check_ctl("reset_ctl", 6'b000000);
    check_eq("reset_fwd", 32'({fwd_a, fwd_b}), 'h0);
    check_eq("reset_cnts", 32'({stall_cnt, flush_cnt}), 'h0);
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #3;
    check_ctl("idle_ctl", 6'b000000);
    check_eq("idle_stall_cnt", 32'(stall_cnt), 'd0);

    // lw r2 in EX, add r3,r2,r4 in ID
    next_cycle();
    memread_EX = 1'b1; wen_EX = 1'b1; waddr_EX = 5'd2;
    rs_ID = 5'd2; rt_ID = 5'd4; uses_rt_ID = 1'b1;
    #3 check_ctl("lu_ex_c0", 6'b111000);
    next_cycle();
    memread_EX = 1'b0; wen_EX = 1'b0; waddr_EX = '0;
    memread_MEM = 1'b1; wen_MEM = 1'b1; waddr_MEM = 5'd2;
    #3 check_ctl("lu_ex_c1", 6'b111001);
    check_eq("lu_ex_cnt1", 32'(stall_cnt), 'd1);
    next_cycle();
    memread_MEM = 1'b0; wen_MEM = 1'b0; waddr_MEM = '0;
    wen_WB = 1'b1; waddr_WB = 5'd2;
    #3 check_ctl("lu_ex_release", 6'b000001);
    check_eq("lu_ex_cnt2", 32'(stall_cnt), 'd2);
    next_cycle();
    rs_ID = '0; rt_ID = '0; uses_rt_ID = 1'b0;
    rs_EX = 5'd2; rt_EX = 5'd4;
    #3 check_ctl("lu_ex_run", 6'b000000);
    check_eq("lu_ex_fwd", 32'({fwd_a, fwd_b}), 'b1000);

    // lw r2 in MEM, independent in EX, add r3,r2,r4 in ID
    next_cycle();
    clear_inputs();
    memread_MEM = 1'b1; wen_MEM = 1'b1; waddr_MEM = 5'd2;
    wen_EX = 1'b1; waddr_EX = 5'd7;
    rs_ID = 5'd2; rt_ID = 5'd4; uses_rt_ID = 1'b1;
    #3 check_ctl("lu_mem_c0", 6'b111000);
    next_cycle();
    clear_inputs();
    wen_WB = 1'b1; waddr_WB = 5'd2; rs_ID = 5'd2; rt_ID = 5'd4; uses_rt_ID = 1'b1;
    #3 check_ctl("lu_mem_release", 6'b000001);
    check_eq("lu_mem_cnt", 32'(stall_cnt), 'd3);

    // rt match without uses_rt, and load to r0: no stall
    next_cycle();
    clear_inputs();
    memread_EX = 1'b1; wen_EX = 1'b1; waddr_EX = 5'd5;
    rs_ID = 5'd1; rt_ID = 5'd5; uses_rt_ID = 1'b0;
    #3 check_ctl("no_rt_use", 6'b000000);
    next_cycle();
    waddr_EX = '0; rs_ID = '0; rt_ID = '0; uses_rt_ID = 1'b1;
    #3 check_ctl("load_r0", 6'b000000);

    // Forwarding patterns
    next_cycle();
    clear_inputs();
    wen_MEM = 1'b1; waddr_MEM = 5'd1; rs_EX = 5'd1; rt_EX = 5'd1;
    #3 check_eq("fwd_mem", 32'({fwd_a, fwd_b}), 'b0101);
    next_cycle();
    wen_MEM = 1'b0; waddr_MEM = '0; wen_WB = 1'b1; waddr_WB = 5'd1;
    #3 check_eq("fwd_wb", 32'({fwd_a, fwd_b}), 'b1010);
    next_cycle();
    wen_MEM = 1'b1; waddr_MEM = 5'd1;
    #3 check_eq("fwd_prio", 32'({fwd_a, fwd_b}), 'b0101);
    next_cycle();
    memread_MEM = 1'b1;
    #3 check_eq("fwd_mem_load", 32'({fwd_a, fwd_b}), 'b1010);
    next_cycle();
    memread_MEM = 1'b0; waddr_MEM = '0; waddr_WB = '0; rs_EX = '0; rt_EX = '0;
    #3 check_eq("fwd_r0", 32'({fwd_a, fwd_b}), 'b0000);
    next_cycle();
    waddr_MEM = 5'd1; waddr_WB = 5'd3; rs_EX = 5'd1; rt_EX = 5'd3;
    #3 check_eq("fwd_split", 32'({fwd_a, fwd_b}), 'b0110);

    // Taken branch, FLUSH_CYCLES = 2; hazard presented during FLUSH is ignored
    next_cycle();
    clear_inputs();
    branch_taken_EX = 1'b1;
    #3 check_ctl("br_c0", 6'b001110);
    check_eq("br_cnt0", 32'(flush_cnt), 'd0);
    next_cycle();
    branch_taken_EX = 1'b0;
    memread_EX = 1'b1; wen_EX = 1'b1; waddr_EX = 5'd6; rs_ID = 5'd6;
    #3 check_ctl("br_c1", 6'b001011);
    check_eq("br_cnt1", 32'(flush_cnt), 'd1);
    next_cycle();
    clear_inputs();
    #3 check_ctl("br_c2", 6'b000000);
    check_eq("br_no_stall", 32'(stall_cnt), 'd3);

    // Branch and load-use in the same cycle: redirect wins
    next_cycle();
    branch_taken_EX = 1'b1;
    memread_EX = 1'b1; wen_EX = 1'b1; waddr_EX = 5'd6; rs_ID = 5'd6;
    #3 check_ctl("prio_c0", 6'b001110);
    next_cycle();
    clear_inputs();
    #3 check_ctl("prio_c1", 6'b001011);
    next_cycle();
    #3 check_ctl("prio_c2", 6'b000000);
    check_eq("prio_stall_cnt", 32'(stall_cnt), 'd3);
    check_eq("prio_flush_cnt", 32'(flush_cnt), 'd2);

    // Saturation: 17 stall cycles on both instances
    next_cycle();
    rst = 1'b1;
    #2 rst = 1'b0;
    memread_EX = 1'b1; wen_EX = 1'b1; waddr_EX = 5'd9; rs_ID = 5'd9;
    for (int i = 0; i < 17; i++) begin
      next_cycle();
    end
    check_eq("sat_wide", 32'(stall_cnt), 'd17);
    check_eq("sat_narrow", 32'(s_stall_cnt), 'd15);
    check_ctl("sat_stall_ctl", 6'b111001);

    // Reset asserted mid-STALL: outputs drop immediately
    wen_MEM = 1'b1; waddr_MEM = 5'd4; rs_EX = 5'd4; rt_EX = 5'd4;
    #2 rst = 1'b1;
    #1;
    check_ctl("rst_mid_ctl", 6'b000000);
    check_eq("rst_mid_fwd", 32'({fwd_a, fwd_b}), 'h0);
    check_eq("rst_mid_cnt", 32'({s_stall_cnt, stall_cnt}), 'h0);
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    #3 check_ctl("post_rst", 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 4-stage pipelined CPU: IF/ID, ID/EXE, EX/MEM, MEM/WB.
- Detects load-use hazards and holds the front of the pipe for them.
- Produces ALU operand forwarding selects.
- On a taken branch resolved in EX, redirects the PC and flushes wrong-path instructions.
- Keeps saturating stall and flush event counters for debug.
- Sits beside the top-level pipeline and drives the PC enable, pipeline-register bubble/flush controls, and the ALU input muxes.

Parameters:
- ASIZE, 5, register address width.
- CNT_W, 16, width of the stall and flush counters.
- FLUSH_CYCLES, 2, cycles of wrong-path squash after a taken branch. Covers the 1-cycle instruction-memory latency. Legal values 1..3.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- rs_ID  input  ASIZE  INST[25:21] of the instruction in ID
- rt_ID  input  ASIZE  INST[20:16] of the instruction in ID
- uses_rt_ID  input  1  ID instruction reads rt (R-type, store, branch)
- waddr_EX  input  ASIZE  destination register in ID/EXE
- wen_EX  input  1  write enable in ID/EXE
- memread_EX  input  1  ID/EXE instruction is a load
- waddr_MEM  input  ASIZE  destination register in EX/MEM
- wen_MEM  input  1  write enable in EX/MEM
- memread_MEM  input  1  EX/MEM instruction is a load
- waddr_WB  input  ASIZE  destination register in MEM/WB
- wen_WB  input  1  write enable in MEM/WB
- rs_EX  input  ASIZE  rs captured in ID/EXE
- rt_EX  input  ASIZE  rt captured in ID/EXE
- branch_taken_EX  input  1  zero AND branch in ID/EXE
- pc_hold  output  1  PC keeps its value this cycle
- ifid_hold  output  1  instruction register and IF/ID contents held
- idex_bubble  output  1  ID/EXE loads zeros for all control fields (wen, memwrite, memread, branch)
- pc_redirect  output  1  PC loads the branch target instead of PC+1
- flush_id  output  1  instruction in ID is squashed (its controls zeroed into ID/EXE)
- fwd_a  output  2  ALU operand A select: 00 ID/EXE, 01 EX/MEM result, 10 WB data
- fwd_b  output  2  ALU operand B select, same encoding; applied before the alusrc mux
- stall_cnt  output  CNT_W  stall cycles since reset, saturating
- flush_cnt  output  CNT_W  taken branches since reset, saturating
- busy  output  1  FSM not in RUN

Behaviour:
- Reset:
  - Asynchronous; FSM to RUN; internal flush counter and both event counters cleared.
  - While rst is high, every output is 0.
- States:
  - RUN: normal issue.
  - STALL: load-use hold.
  - FLUSH: squash wrong path.
- Load-use match:
  - hazEX = memread_EX & wen_EX & (waddr_EX != 0) & (waddr_EX == rs_ID | (uses_rt_ID & waddr_EX == rt_ID)).
  - hazMEM is the same expression with the _MEM signals. Data memory read has 1-cycle latency, so the loaded value is first forwardable from WB.
- RUN:
  - If branch_taken_EX: pc_redirect=1, flush_id=1, idex_bubble=1; flush_cnt++; go to FLUSH with the remaining count = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN.
  - Else if hazEX or hazMEM: pc_hold=1, ifid_hold=1, idex_bubble=1; stall_cnt++; go to STALL.
  - Else: all controls 0.
- STALL:
  - Hold outputs exactly as in RUN; re-evaluate each cycle.
  - If neither hazard is present, return to RUN with all controls 0 that cycle.
  - A load in EX needs 2 stall cycles total; a load in MEM needs 1.
  - branch_taken_EX cannot occur in STALL because ID/EXE holds a bubble. If it does occur, it takes priority exactly as in RUN.
- FLUSH:
  - flush_id=1, idex_bubble=1, pc_hold=0; the counter decrements each cycle.
  - At 0, go to RUN.
  - Hazard checks are ignored in FLUSH.
  - A new branch_taken_EX in FLUSH is impossible (bubbles only) and is ignored.
- Priority: branch redirect > load-use stall > none, whenever both conditions occur in the same cycle.
- Forwarding (combinational, all states):
  - fwd_a=01 if wen_MEM & !memread_MEM & waddr_MEM != 0 & waddr_MEM == rs_EX.
  - Else fwd_a=10 if wen_WB & waddr_WB != 0 & waddr_WB == rs_EX.
  - Else 00.
  - fwd_b is identical using rt_EX.
  - EX/MEM takes priority over WB.
- Counters:
  - Increment on the entry cycle and on every held STALL cycle (stall_cnt), or once per taken branch (flush_cnt).
  - Saturate at all-ones; no wrap.
- busy = (state != RUN).

Test Plan:
- lw r2 then add r3,r2,r4 back-to-back -> 2 cycles of pc_hold=ifid_hold=idex_bubble=1; then fwd_a=10 in EX; stall_cnt=2.
- lw r2, independent instruction, add r3,r2,r4 -> 1 stall cycle (hazMEM); stall_cnt=1.
- add r1; sub r5,r1,r1 -> no stall; fwd_a=fwd_b=01. With one instruction between them -> fwd_a=fwd_b=10. Writes to r0 -> fwd stays 00.
- beq taken (branch_taken_EX=1) with FLUSH_CYCLES=2 -> cycle 0: pc_redirect=1, flush_id=1, idex_bubble=1; cycle 1: flush_id=1, busy=1; cycle 2: RUN; flush_cnt=1.
- Taken branch and load-use hazard in the same cycle -> redirect only; stall_cnt unchanged.
- Assert rst mid-STALL; force stall_cnt near saturation (CNT_W=4, 17 stalls) -> all outputs 0 immediately and state RUN; counter holds at 15.
